wb_cache: RTL and testbench

// - Direct-mapped, write-through, no-write-allocate cache between the CPU Wishbone bus and the SDRAM controller.
// - The slave (S_*) side serves the SDRAM window 0x1400-0x23FF after the SoC address decoder.
// - The master (M_*) side performs 4-word line fills and single-word write-throughs to the memory controller.
// - Addresses pass through unmodified; the memory controller does its own address masking.

---
 rtl/wb_cache.sv | 218 +++++++++++++++++++++
 tb/tb_wb_cache.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_cache.sv
// Direct-mapped, write-through, no-write-allocate Wishbone cache in front of the SDRAM controller.
// Read misses fill a 4-word line with an incrementing burst; writes go straight through to memory.
module wb_cache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        S_STB,
  input  logic        S_CYC,
  input  logic [31:0] S_ADR,
  input  logic [31:0] S_DAT_O,
  input  logic [2:0]  S_CTI_O,
  input  logic        S_WE,
  output logic [31:0] S_DAT_I,
  output logic        S_ACK,
  output logic        S_ERR,
  output logic        S_RTY,
  input  logic        M_ACK,
  input  logic        M_ERR,
  input  logic        M_RTY,
  input  logic [31:0] M_DAT_I,
  output logic        M_STB,
  output logic        M_CYC,
  output logic [31:0] M_ADR,
  output logic [31:0] M_DAT_O,
  output logic [2:0]  M_CTI_O,
  output logic        M_WE
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, RESP, FILL, WRITE} state_t;

  state_t           state, state_nxt;
  logic [LINES-1:0] valid, valid_nxt;
  logic [1:0]       beat, beat_nxt;
  logic [31:0]      s_dat, s_dat_nxt;
  logic             s_ack, s_ack_nxt;
  logic             s_err, s_err_nxt;
  logic             s_rty, s_rty_nxt;
  logic             m_stb, m_stb_nxt;
  logic             m_we, m_we_nxt;
  logic [31:0]      m_adr, m_adr_nxt;
  logic [31:0]      m_dat, m_dat_nxt;
  logic [2:0]       m_cti, m_cti_nxt;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][LINE_WORDS];
  logic [31:0]      req_adr;
  logic             req_ld;
  logic             data_we;
  logic             tag_we;
  logic [1:0]       data_off;
  logic [31:0]      data_wdat;

  logic [IDX_W-1:0] s_idx, r_idx;
  logic [TAG_W-1:0] s_tag, r_tag;
  logic [1:0]       s_off, r_off;
  logic             s_hit, r_hit, s_req;
  logic             unused_bits;

  assign s_idx = S_ADR[4 +: IDX_W];
  assign s_tag = S_ADR[31 -: TAG_W];
  assign s_off = S_ADR[3:2];
  assign r_idx = req_adr[4 +: IDX_W];
  assign r_tag = req_adr[31 -: TAG_W];
  assign r_off = req_adr[3:2];
  assign s_hit = valid[s_idx] && (tag_mem[s_idx] == s_tag);
  assign r_hit = valid[r_idx] && (tag_mem[r_idx] == r_tag);
  // While an ERR/RTY pulse is out the master has not yet dropped STB; don't take that as a new request.
  assign s_req = S_STB && S_CYC && !s_err && !s_rty;
  assign unused_bits = ^{S_CTI_O, S_ADR[1:0], req_adr[1:0]};

  assign S_DAT_I = s_dat;
  assign S_ACK   = s_ack;
  assign S_ERR   = s_err;
  assign S_RTY   = s_rty;
  assign M_STB   = m_stb;
  assign M_CYC   = m_stb;
  assign M_ADR   = m_adr;
  assign M_DAT_O = m_dat;
  assign M_CTI_O = m_cti;
  assign M_WE    = m_we;

  always_comb begin
    state_nxt = state;
    valid_nxt = valid;
    beat_nxt  = beat;
    s_dat_nxt = s_dat;
    s_ack_nxt = 1'b0;
    s_err_nxt = 1'b0;
    s_rty_nxt = 1'b0;
    m_stb_nxt = m_stb;
    m_we_nxt  = m_we;
    m_adr_nxt = m_adr;
    m_dat_nxt = m_dat;
    m_cti_nxt = m_cti;
    req_ld    = 1'b0;
    data_we   = 1'b0;
    tag_we    = 1'b0;
    data_off  = beat;
    data_wdat = M_DAT_I;
    case (state)
      IDLE: begin
        if (s_req) begin
          req_ld = 1'b1;
          if (S_WE) begin
            m_adr_nxt = {S_ADR[31:2], 2'b00};
            m_dat_nxt = S_DAT_O;
            m_we_nxt  = 1'b1;
            m_cti_nxt = 3'b000;
            m_stb_nxt = 1'b1;
            state_nxt = WRITE;
          end else if (s_hit) begin
            s_dat_nxt = data_mem[s_idx][s_off];
            s_ack_nxt = 1'b1;
            state_nxt = RESP;
          end else begin
            m_adr_nxt = {S_ADR[31:4], 4'b0000};
            beat_nxt  = 2'd0;
            m_we_nxt  = 1'b0;
            m_cti_nxt = 3'b010;
            m_stb_nxt = 1'b1;
            state_nxt = FILL;
          end
        end
      end
      RESP: state_nxt = IDLE;
      FILL: begin
        if (M_ERR || M_RTY) begin
          m_stb_nxt        = 1'b0;
          m_cti_nxt        = 3'b000;
          valid_nxt[r_idx] = 1'b0;
          s_err_nxt        = M_ERR;
          s_rty_nxt        = !M_ERR;
          state_nxt        = IDLE;
        end else if (M_ACK) begin
          data_we = 1'b1;
          if (beat == 2'd3) begin
            m_stb_nxt        = 1'b0;
            m_cti_nxt        = 3'b000;
            valid_nxt[r_idx] = 1'b1;
            tag_we           = 1'b1;
            // The last beat is still in flight to the array, so forward it directly.
            s_dat_nxt        = (r_off == 2'd3) ? M_DAT_I : data_mem[r_idx][r_off];
            s_ack_nxt        = 1'b1;
            state_nxt        = RESP;
          end else begin
            beat_nxt  = beat + 2'd1;
            m_adr_nxt = m_adr + 32'd4;
            if (beat == 2'd2) m_cti_nxt = 3'b111;
          end
        end
      end
      WRITE: begin
        if (M_ERR || M_RTY) begin
          m_stb_nxt = 1'b0;
          m_we_nxt  = 1'b0;
          s_err_nxt = M_ERR;
          s_rty_nxt = !M_ERR;
          state_nxt = IDLE;
        end else if (M_ACK) begin
          m_stb_nxt = 1'b0;
          m_we_nxt  = 1'b0;
          if (r_hit) begin
            data_we   = 1'b1;
            data_off  = r_off;
            data_wdat = m_dat;
          end
          s_ack_nxt = 1'b1;
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and bus-visible registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      beat  <= 2'd0;
      s_dat <= 32'd0;
      s_ack <= 1'b0;
      s_err <= 1'b0;
      s_rty <= 1'b0;
      m_stb <= 1'b0;
      m_we  <= 1'b0;
      m_adr <= 32'd0;
      m_dat <= 32'd0;
      m_cti <= 3'b000;
    end else begin
      state <= state_nxt;
      valid <= valid_nxt;
      beat  <= beat_nxt;
      s_dat <= s_dat_nxt;
      s_ack <= s_ack_nxt;
      s_err <= s_err_nxt;
      s_rty <= s_rty_nxt;
      m_stb <= m_stb_nxt;
      m_we  <= m_we_nxt;
      m_adr <= m_adr_nxt;
      m_dat <= m_dat_nxt;
      m_cti <= m_cti_nxt;
    end
  end

  // Tag/data storage and the latched request address
  always_ff @(posedge clk) begin
    if (data_we) data_mem[r_idx][data_off] <= data_wdat;
    if (tag_we)  tag_mem[r_idx] <= r_tag;
    if (req_ld)  req_adr <= S_ADR;
  end

endmodule

// File: tb/tb_wb_cache.sv
// Directed bench for wb_cache: a zero-wait memory responder with one-shot ERR/RTY injection,
// and CPU transfers checked against hand-computed addresses, beat counts and data.
module tb_wb_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        S_STB = 1'b0, S_CYC = 1'b0, S_WE = 1'b0;
  logic [31:0] S_ADR = '0, S_DAT_O = '0;
  logic [2:0]  S_CTI_O = '0;
  logic [31:0] S_DAT_I;
  logic        S_ACK, S_ERR, S_RTY;
  logic        M_ACK = 1'b0, M_ERR = 1'b0, M_RTY = 1'b0;
  logic [31:0] M_DAT_I = '0;
  logic        M_STB, M_CYC, M_WE;
  logic [31:0] M_ADR, M_DAT_O;
  logic [2:0]  M_CTI_O;

  wb_cache #(.LINES(16), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .S_STB(S_STB), .S_CYC(S_CYC), .S_ADR(S_ADR), .S_DAT_O(S_DAT_O), .S_CTI_O(S_CTI_O),
    .S_WE(S_WE), .S_DAT_I(S_DAT_I), .S_ACK(S_ACK), .S_ERR(S_ERR), .S_RTY(S_RTY),
    .M_ACK(M_ACK), .M_ERR(M_ERR), .M_RTY(M_RTY), .M_DAT_I(M_DAT_I),
    .M_STB(M_STB), .M_CYC(M_CYC), .M_ADR(M_ADR), .M_DAT_O(M_DAT_O),
    .M_CTI_O(M_CTI_O), .M_WE(M_WE)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nmis = 0;
  int          nbeats = 0;
  int          mstb_cnt = 0;
  logic [31:0] log_adr [8];
  logic [2:0]  log_cti [8];
  logic        log_we  [8];
  logic [31:0] log_dat [8];
  logic [31:0] err_adr = 32'hFFFF_FFFF;
  logic [31:0] rty_adr = 32'hFFFF_FFFF;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    if (a[31:4] == 28'h0000140) return 32'hA0 + {30'd0, a[3:2]};
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory side: responds on the negedge after seeing M_STB, so each beat takes one cycle.
  initial begin
    forever begin
      @(negedge clk);
      M_ACK = 1'b0; M_ERR = 1'b0; M_RTY = 1'b0;
      if (M_STB && !rst) begin
        mstb_cnt++;
        if (M_ADR == err_adr) begin
          M_ERR = 1'b1; err_adr = 32'hFFFF_FFFF;
        end else if (M_ADR == rty_adr) begin
          M_RTY = 1'b1; rty_adr = 32'hFFFF_FFFF;
        end else begin
          M_ACK = 1'b1;
          if (M_WE) mem[M_ADR] = M_DAT_O;
          else M_DAT_I = memval(M_ADR);
          if (nbeats < 8) begin
            log_adr[nbeats] = M_ADR; log_cti[nbeats] = M_CTI_O;
            log_we[nbeats] = M_WE;   log_dat[nbeats] = M_DAT_O;
          end
          nbeats++;
        end
      end
    end
  end

  task automatic cpu_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          output logic [31:0] rdat, output int resp, output int cyc);
    @(negedge clk);
    nbeats = 0; mstb_cnt = 0;
    S_ADR = adr; S_WE = we; S_DAT_O = dat; S_STB = 1'b1; S_CYC = 1'b1;
    resp = -1; cyc = 0; rdat = '0;
    while (resp < 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (S_ACK || S_ERR || S_RTY) begin
        resp = S_ACK ? 0 : (S_ERR ? 1 : 2);
        chk("resp_onehot", $countones({S_ACK, S_ERR, S_RTY}), 1);
        rdat = S_DAT_I;
        S_STB = 1'b0; S_CYC = 1'b0;
      end
    end
    if (resp < 0) begin
      chk("resp_timeout", 32'd1, 32'd0);
      S_STB = 1'b0; S_CYC = 1'b0;
    end
    @(posedge clk); #1;
    chk("resp_single_pulse", {29'd0, S_ACK, S_ERR, S_RTY}, 32'd0);
  endtask

  logic [31:0] rd;
  int          resp, cyc, w;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_out", {29'd0, S_ACK, S_ERR, S_RTY}, 32'd0);
    chk("rst_m_ctl", {28'd0, M_STB, M_CYC, M_WE, 1'b0}, 32'd0);
    chk("rst_m_cti", {29'd0, M_CTI_O}, 32'd0);
    chk("rst_m_adr", M_ADR, 32'd0);
    chk("rst_m_dat", M_DAT_O, 32'd0);
    chk("rst_s_dat", S_DAT_I, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Read miss: burst from line base, requested word returned
    cpu_xfer(1'b0, 32'h1408, 32'd0, rd, resp, cyc);
    chk("miss_resp", resp, 0);
    chk("miss_beats", nbeats, 4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_adr", log_adr[i], 32'h1400 + 32'(4 * i));
      chk("fill_cti", {29'd0, log_cti[i]}, (i == 3) ? 32'd7 : 32'd2);
    end
    chk("miss_dat", rd, 32'hA2);
    chk("miss_cyc", cyc, 5);

    // Read hit: one-cycle ACK, no memory traffic
    cpu_xfer(1'b0, 32'h140C, 32'd0, rd, resp, cyc);
    chk("hit_resp", resp, 0);
    chk("hit_cyc", cyc, 1);
    chk("hit_dat", rd, 32'hA3);
    chk("hit_no_mstb", mstb_cnt, 0);

    // Write hit: single write-through, cached word updated
    cpu_xfer(1'b1, 32'h1404, 32'h1234_5678, rd, resp, cyc);
    chk("wr_resp", resp, 0);
    chk("wr_beats", nbeats, 1);
    chk("wr_mstb_cycles", mstb_cnt, 1);
    chk("wr_adr", log_adr[0], 32'h1404);
    chk("wr_cti", {29'd0, log_cti[0]}, 32'd0);
    chk("wr_we", {31'd0, log_we[0]}, 32'd1);
    chk("wr_dat", log_dat[0], 32'h1234_5678);
    chk("wr_cyc", cyc, 2);
    cpu_xfer(1'b0, 32'h1404, 32'd0, rd, resp, cyc);
    chk("wr_rd_hit", mstb_cnt, 0);
    chk("wr_rd_dat", rd, 32'h1234_5678);

    // Write miss: write-through, no allocation
    cpu_xfer(1'b1, 32'h1800, 32'hDEAD_BEEF, rd, resp, cyc);
    chk("wm_resp", resp, 0);
    chk("wm_beats", nbeats, 1);
    chk("wm_adr", log_adr[0], 32'h1800);
    cpu_xfer(1'b0, 32'h1800, 32'd0, rd, resp, cyc);
    chk("wm_rd_beats", nbeats, 4);
    chk("wm_rd_adr0", log_adr[0], 32'h1800);
    chk("wm_rd_dat", rd, 32'hDEAD_BEEF);

    // Error on beat 2 of a fill, then a full refetch
    err_adr = 32'h1508;
    cpu_xfer(1'b0, 32'h1500, 32'd0, rd, resp, cyc);
    chk("err_resp", resp, 1);
    chk("err_beats", nbeats, 2);
    cpu_xfer(1'b0, 32'h1500, 32'd0, rd, resp, cyc);
    chk("refetch_resp", resp, 0);
    chk("refetch_beats", nbeats, 4);
    chk("refetch_adr0", log_adr[0], 32'h1500);
    chk("refetch_adr3", log_adr[3], 32'h150C);
    chk("refetch_dat", rd, 32'h5A5A_1500);

    // Retry on a write-through
    rty_adr = 32'h1600;
    cpu_xfer(1'b1, 32'h1600, 32'h0BAD_F00D, rd, resp, cyc);
    chk("rty_resp", resp, 2);
    chk("rty_beats", nbeats, 0);

    // Reset in the middle of a fill clears every line
    cpu_xfer(1'b0, 32'h1424, 32'd0, rd, resp, cyc);
    chk("l2_dat", rd, 32'h5A5A_1424);
    @(negedge clk);
    nbeats = 0;
    S_ADR = 32'h1400; S_WE = 1'b0; S_STB = 1'b1; S_CYC = 1'b1;
    w = 0;
    while (nbeats < 2 && w < 50) begin
      @(posedge clk); w++;
    end
    chk("midfill_reached", {31'd0, w < 50}, 32'd1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_ctl", {26'd0, M_STB, M_CYC, M_WE, S_ACK, S_ERR, S_RTY}, 32'd0);
    chk("midrst_adr", M_ADR, 32'd0);
    chk("midrst_cti", {29'd0, M_CTI_O}, 32'd0);
    chk("midrst_mdat", M_DAT_O, 32'd0);
    chk("midrst_sdat", S_DAT_I, 32'd0);
    S_STB = 1'b0; S_CYC = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    cpu_xfer(1'b0, 32'h1424, 32'd0, rd, resp, cyc);
    chk("post_rst_l2_miss", nbeats, 4);
    chk("post_rst_l2_dat", rd, 32'h5A5A_1424);
    cpu_xfer(1'b0, 32'h1400, 32'd0, rd, resp, cyc);
    chk("post_rst_miss", nbeats, 4);
    chk("post_rst_dat", rd, 32'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
